// File: rtl/draw_frame_scheduler_if.sv
// rtl/draw_frame_scheduler_if.sv - pass-engine handshake and VGA pixel bus around the draw scheduler
interface draw_frame_scheduler_if;
    logic        bgStart, noteStart, keyStart;
    logic        bgDone, noteDone, keyDone;
    logic [7:0]  bgX, bgY, noteX, noteY, keyX, keyY;
    logic [23:0] bgColour, noteColour, keyColour;
    logic        bgPlot, notePlot, keyPlot;
    logic [7:0]  vgaX, vgaY;
    logic [23:0] vgaColour;
    logic        vgaPlot;

    modport master (
        output bgStart, noteStart, keyStart,
        output vgaX, vgaY, vgaColour, vgaPlot,
        input  bgDone, noteDone, keyDone,
        input  bgX, bgY, noteX, noteY, keyX, keyY,
        input  bgColour, noteColour, keyColour,
        input  bgPlot, notePlot, keyPlot
    );

    modport slave (
        input  bgStart, noteStart, keyStart,
        input  vgaX, vgaY, vgaColour, vgaPlot,
        output bgDone, noteDone, keyDone,
        output bgX, bgY, noteX, noteY, keyX, keyY,
        output bgColour, noteColour, keyColour,
        output bgPlot, notePlot, keyPlot
    );
endinterface

// File: rtl/draw_frame_scheduler.sv
// rtl/draw_frame_scheduler.sv - sequences background, note and key draw passes onto the single VGA write port
// Optional per-pass watchdog enabled by defining DRAW_WATCHDOG_EN.
`ifndef RECORD
`define RECORD 5'd4
`endif

module draw_frame_scheduler #(
    parameter int WDOG_CYCLES = 20000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frameTick,
    input  logic [4:0]                    currentState,
    draw_frame_scheduler_if.master        bus,
    output logic                          busy,
    output logic                          frameDone,
    output logic [7:0]                    overrunCount,
    output logic                          timeoutFlag
);

    typedef enum logic [2:0] {
        IDLE, START_BG, RUN_BG, START_NOTE, RUN_NOTE, START_KEY, RUN_KEY, DONE
    } state_t;

    state_t state, stateNext;
    logic   pending;
    logic   inRun;
    logic   activeDone;
    logic   wdogExpired;
    logic   passEnd;

    assign inRun = (state == RUN_BG) || (state == RUN_NOTE) || (state == RUN_KEY);

    // Only the engine that owns the bus may end the current pass.
    always_comb begin
        activeDone = 1'b0;
        case (state)
            RUN_BG:   activeDone = bus.bgDone;
            RUN_NOTE: activeDone = bus.noteDone;
            RUN_KEY:  activeDone = bus.keyDone;
            default:  activeDone = 1'b0;
        endcase
    end

`ifdef DRAW_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
    logic [15:0] wdogCount;

    assign wdogExpired = (wdogCount == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (reset || !inRun) begin
            wdogCount <= '0;
        end else begin
            wdogCount <= wdogCount + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeoutFlag <= 1'b0;
        end else if (inRun && wdogExpired && !activeDone) begin
            timeoutFlag <= 1'b1;
        end
    end
`else
    assign wdogExpired = 1'b0;
    assign timeoutFlag = 1'b0;
`endif

    assign passEnd = activeDone || (inRun && wdogExpired);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:       if (frameTick || pending) stateNext = START_BG;
            START_BG:   stateNext = RUN_BG;
            RUN_BG:     if (passEnd) stateNext = (currentState == `RECORD) ? START_KEY : START_NOTE;
            START_NOTE: stateNext = RUN_NOTE;
            RUN_NOTE:   if (passEnd) stateNext = START_KEY;
            START_KEY:  stateNext = RUN_KEY;
            RUN_KEY:    if (passEnd) stateNext = DONE;
            DONE:       stateNext = IDLE;
            default:    stateNext = IDLE;
        endcase
    end

    assign bus.bgStart   = (state == START_BG);
    assign bus.noteStart = (state == START_NOTE);
    assign bus.keyStart  = (state == START_KEY);
    assign frameDone     = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (stateNext != IDLE);
        end
    end

    // IDLE always consumes the single queued request; ticks that find it already full are counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= 1'b0;
            overrunCount <= '0;
        end else begin
            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (frameTick) begin
                pending <= 1'b1;
            end
            if (frameTick && pending && (overrunCount != 8'hFF)) begin
                overrunCount <= overrunCount + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.vgaX      <= '0;
            bus.vgaY      <= '0;
            bus.vgaColour <= '0;
            bus.vgaPlot   <= 1'b0;
        end else begin
            case (state)
                RUN_BG: begin
                    bus.vgaX      <= bus.bgX;
                    bus.vgaY      <= bus.bgY;
                    bus.vgaColour <= bus.bgColour;
                    bus.vgaPlot   <= bus.bgPlot;
                end
                RUN_NOTE: begin
                    bus.vgaX      <= bus.noteX;
                    bus.vgaY      <= bus.noteY;
                    bus.vgaColour <= bus.noteColour;
                    bus.vgaPlot   <= bus.notePlot;
                end
                RUN_KEY: begin
                    bus.vgaX      <= bus.keyX;
                    bus.vgaY      <= bus.keyY;
                    bus.vgaColour <= bus.keyColour;
                    bus.vgaPlot   <= bus.keyPlot;
                end
                default: bus.vgaPlot <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_frame_scheduler.sv
// tb/tb_draw_frame_scheduler.sv - self-checking bench for draw_frame_scheduler
`ifndef RECORD
`define RECORD 5'd4
`endif

module tb_draw_frame_scheduler;
    localparam int SN = 200;
    localparam int RN = 1200;

    logic       clk = 1'b0;
    logic       reset;
    logic       frameTick;
    logic [4:0] currentState;
    logic       busy, frameDone, timeoutFlag;
    logic [7:0] overrunCount;
    int errors = 0;
    int checks = 0;

    draw_frame_scheduler_if bus();

    draw_frame_scheduler #(.WDOG_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .frameTick(frameTick), .currentState(currentState),
        .bus(bus), .busy(busy), .frameDone(frameDone),
        .overrunCount(overrunCount), .timeoutFlag(timeoutFlag)
    );

    always #5 clk = ~clk;

    bit          smpBg[SN], smpNote[SN], smpKey[SN], smpFd[SN], smpBusy[SN], smpPlot[SN], smpTo[SN];
    logic [7:0]  smpVx[SN], smpVy[SN], smpOvr[SN];
    logic [23:0] smpVc[SN];

    bit expBgS[RN], expNoteS[RN], expKeyS[RN], expFd[RN], expBusy[RN];
    bit doneBg[RN], doneNote[RN], doneKey[RN];
    int owner[RN];

    // Scripted engines: each pulses done six cycles after its start pulse, i.e. five cycles into its run.
    task automatic runFrame(input int nCyc, input int t0, input int t1, input int t2, input int t3,
                            input bit rec, input int resetAt, input bit holdNote);
        int bgD = -1, noteD = -1, keyD = -1;
        for (int r = 0; r < nCyc; r++) begin
            frameTick      = (r == t0) || (r == t1) || (r == t2) || (r == t3);
            reset          = (r == resetAt);
            currentState   = rec ? `RECORD : (`RECORD ^ 5'd1);
            bus.bgDone     = (r == bgD);
            bus.noteDone   = (r == noteD) && !holdNote;
            bus.keyDone    = (r == keyD);
            bus.bgX        = 8'(r);
            bus.bgY        = 8'd7;
            bus.bgColour   = 24'h001000 | 24'(r);
            bus.bgPlot     = 1'b1;
            bus.noteX      = 8'd40;
            bus.noteY      = 8'd50;
            bus.noteColour = 24'hFF0000;
            bus.notePlot   = 1'b1;
            bus.keyX       = 8'(r + 100);
            bus.keyY       = 8'd9;
            bus.keyColour  = 24'h0000FF;
            bus.keyPlot    = 1'b1;
            @(negedge clk);
            smpBg[r] = bus.bgStart;   smpNote[r] = bus.noteStart; smpKey[r] = bus.keyStart;
            smpFd[r] = frameDone;     smpBusy[r] = busy;          smpPlot[r] = bus.vgaPlot;
            smpVx[r] = bus.vgaX;      smpVy[r] = bus.vgaY;        smpVc[r] = bus.vgaColour;
            smpOvr[r] = overrunCount; smpTo[r] = timeoutFlag;
            if (bus.bgStart)   bgD   = r + 6;
            if (bus.noteStart) noteD = r + 6;
            if (bus.keyStart)  keyD  = r + 6;
            @(posedge clk); #1;
        end
        frameTick = 1'b0; reset = 1'b0;
        bus.bgDone = 1'b0; bus.noteDone = 1'b0; bus.keyDone = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; frameTick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL reset_frameDone: got %0b want 0", frameDone); end
        checks++; if ({bus.bgStart, bus.noteStart, bus.keyStart} !== 3'b000) begin errors++; $display("FAIL reset_starts: got %b want 000", {bus.bgStart, bus.noteStart, bus.keyStart}); end
        checks++; if ({bus.vgaPlot, bus.vgaX, bus.vgaY, bus.vgaColour} !== 41'd0) begin errors++; $display("FAIL reset_vga: got %0h want 0", {bus.vgaPlot, bus.vgaX, bus.vgaY, bus.vgaColour}); end
        checks++; if (overrunCount !== 8'd0) begin errors++; $display("FAIL reset_overrun: got %0d want 0", overrunCount); end
        checks++; if (timeoutFlag !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b want 0", timeoutFlag); end
        @(posedge clk); #1;
        reset = 1'b0; frameTick = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if ({bus.bgStart, bus.noteStart, bus.keyStart, busy} !== 4'b0000) begin errors++; $display("FAIL reset_after_quiet: got %b want 0000", {bus.bgStart, bus.noteStart, bus.keyStart, busy}); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_normal_frame();
        int nb = 0, nn = 0, nk = 0;
        runFrame(40, 10, -1, -1, -1, 1'b0, -1, 1'b0);
        for (int r = 0; r < 40; r++) begin nb += int'(smpBg[r]); nn += int'(smpNote[r]); nk += int'(smpKey[r]); end
        checks++; if (smpBg[11] !== 1'b1 || nb != 1) begin errors++; $display("FAIL normal_bgStart: at11=%0b count=%0d want 1/1", smpBg[11], nb); end
        checks++; if (smpNote[18] !== 1'b1 || nn != 1) begin errors++; $display("FAIL normal_noteStart: at18=%0b count=%0d want 1/1", smpNote[18], nn); end
        checks++; if (smpKey[25] !== 1'b1 || nk != 1) begin errors++; $display("FAIL normal_keyStart: at25=%0b count=%0d want 1/1", smpKey[25], nk); end
        checks++; if (smpFd[32] !== 1'b1 || smpFd[31] !== 1'b0 || smpFd[33] !== 1'b0) begin errors++; $display("FAIL normal_frameDone: 31..33=%b want 010", {smpFd[31], smpFd[32], smpFd[33]}); end
        checks++; if ({smpBusy[10], smpBusy[11], smpBusy[32], smpBusy[33]} !== 4'b0110) begin errors++; $display("FAIL normal_busy: 10,11,32,33=%b want 0110", {smpBusy[10], smpBusy[11], smpBusy[32], smpBusy[33]}); end
        checks++; if (smpTo[39] !== 1'b0) begin errors++; $display("FAIL normal_timeout: got %0b want 0", smpTo[39]); end
    endtask

    task automatic test_record_skip();
        int nn = 0;
        runFrame(40, 10, -1, -1, -1, 1'b1, -1, 1'b0);
        for (int r = 0; r < 40; r++) nn += int'(smpNote[r]);
        checks++; if (nn != 0) begin errors++; $display("FAIL record_noteStart: count=%0d want 0", nn); end
        checks++; if (smpKey[18] !== 1'b1) begin errors++; $display("FAIL record_keyStart: at18=%0b want 1", smpKey[18]); end
        checks++; if (smpFd[25] !== 1'b1) begin errors++; $display("FAIL record_frameDone: at25=%0b want 1", smpFd[25]); end
    endtask

    // All three engines drive their pixels every cycle; only the running pass may reach the adapter.
    task automatic test_bus_isolation();
        int own;
        logic [7:0] ex, ey;
        logic [23:0] ec;
        runFrame(40, 10, -1, -1, -1, 1'b0, -1, 1'b0);
        for (int r = 1; r < 40; r++) begin
            own = (r - 1 >= 12 && r - 1 <= 17) ? 1 : (r - 1 >= 19 && r - 1 <= 24) ? 2 : (r - 1 >= 26 && r - 1 <= 31) ? 3 : 0;
            ex = (own == 1) ? 8'(r - 1) : (own == 2) ? 8'd40 : 8'(r - 1 + 100);
            ey = (own == 1) ? 8'd7 : (own == 2) ? 8'd50 : 8'd9;
            ec = (own == 1) ? (24'h001000 | 24'(r - 1)) : (own == 2) ? 24'hFF0000 : 24'h0000FF;
            checks++; if (smpPlot[r] !== (own != 0)) begin errors++; $display("FAIL iso_plot@%0d: got %0b want %0b", r, smpPlot[r], own != 0); end
            if (own != 0) begin
                checks++; if ({smpVx[r], smpVy[r], smpVc[r]} !== {ex, ey, ec}) begin errors++; $display("FAIL iso_pixel@%0d: got %0h want %0h", r, {smpVx[r], smpVy[r], smpVc[r]}, {ex, ey, ec}); end
            end
        end
    endtask

    task automatic test_overrun();
        runFrame(70, 10, 14, 20, 26, 1'b0, -1, 1'b0);
        checks++; if (smpOvr[15] !== 8'd0 || smpOvr[21] !== 8'd1) begin errors++; $display("FAIL overrun_step: at15=%0d at21=%0d want 0/1", smpOvr[15], smpOvr[21]); end
        checks++; if (smpOvr[60] !== 8'd2) begin errors++; $display("FAIL overrun_count: got %0d want 2", smpOvr[60]); end
        checks++; if (smpBusy[33] !== 1'b0 || smpBg[33] !== 1'b0 || smpBg[34] !== 1'b1) begin errors++; $display("FAIL overrun_second_frame: busy33=%0b bg33=%0b bg34=%0b want 0/0/1", smpBusy[33], smpBg[33], smpBg[34]); end
        checks++; if (smpFd[55] !== 1'b1) begin errors++; $display("FAIL overrun_second_done: at55=%0b want 1", smpFd[55]); end
    endtask

    task automatic test_reset_mid_pass();
        int ns = 0;
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        runFrame(60, 10, 12, 13, -1, 1'b0, 20, 1'b0);
        for (int r = 21; r < 60; r++) ns += int'(smpBg[r]) + int'(smpNote[r]) + int'(smpKey[r]);
        checks++; if (smpNote[18] !== 1'b1 || smpOvr[19] !== 8'd1) begin errors++; $display("FAIL rstmid_setup: note18=%0b ovr19=%0d want 1/1", smpNote[18], smpOvr[19]); end
        checks++; if ({smpBusy[21], smpPlot[21]} !== 2'b00 || smpOvr[21] !== 8'd0 || smpVx[21] !== 8'd0) begin errors++; $display("FAIL rstmid_outputs: busy=%0b plot=%0b ovr=%0d x=%0d want 0", smpBusy[21], smpPlot[21], smpOvr[21], smpVx[21]); end
        checks++; if (ns != 0) begin errors++; $display("FAIL rstmid_no_start: got %0d starts want 0", ns); end
    endtask

`ifdef DRAW_WATCHDOG_EN
    task automatic test_watchdog();
        runFrame(140, 10, -1, -1, -1, 1'b0, -1, 1'b1);
        checks++; if (smpKey[118] !== 1'b0 || smpKey[119] !== 1'b1) begin errors++; $display("FAIL wdog_keyStart: 118=%0b 119=%0b want 0/1", smpKey[118], smpKey[119]); end
        checks++; if (smpTo[100] !== 1'b0 || smpTo[130] !== 1'b1) begin errors++; $display("FAIL wdog_flag: 100=%0b 130=%0b want 0/1", smpTo[100], smpTo[130]); end
        checks++; if (smpFd[126] !== 1'b1) begin errors++; $display("FAIL wdog_frameDone: at126=%0b want 1", smpFd[126]); end
    endtask
`endif

    // Lays out one whole frame on the cycle timeline from the pass rules; returns the first idle cycle.
    task automatic planFrame(input int n, output int freeAt, output logic [4:0] st);
        int s, rs, dc;
        bit rec;
        s = n + 1;
        expBgS[s] = 1'b1;
        rs = s + 1; dc = rs + int'($urandom_range(0, 5));
        for (int i = rs; i <= dc; i++) owner[i] = 1;
        doneBg[dc] = 1'b1;
        rec = ($urandom_range(0, 3) == 0);
        st = rec ? `RECORD : (`RECORD ^ 5'($urandom_range(1, 31)));
        if (!rec) begin
            expNoteS[dc + 1] = 1'b1;
            rs = dc + 2; dc = rs + int'($urandom_range(0, 5));
            for (int i = rs; i <= dc; i++) owner[i] = 2;
            doneNote[dc] = 1'b1;
        end
        expKeyS[dc + 1] = 1'b1;
        rs = dc + 2; dc = rs + int'($urandom_range(0, 5));
        for (int i = rs; i <= dc; i++) owner[i] = 3;
        doneKey[dc] = 1'b1;
        expFd[dc + 1] = 1'b1;
        for (int i = s; i <= dc + 1; i++) expBusy[i] = 1'b1;
        freeAt = dc + 2;
    endtask

    task automatic test_random();
        int freeAt = 0, ovr = 0, ovrPrev, prevOwn = 0;
        bit pend = 1'b0, tick;
        logic [4:0] st = 5'd0;
        logic [7:0] hx = 8'd0, hy = 8'd0, px = 8'd0, py = 8'd0;
        logic [23:0] hc = 24'd0, pc = 24'd0;
        logic pp = 1'b0, ePlot;
        for (int i = 0; i < RN; i++) begin
            expBgS[i] = 0; expNoteS[i] = 0; expKeyS[i] = 0; expFd[i] = 0; expBusy[i] = 0;
            doneBg[i] = 0; doneNote[i] = 0; doneKey[i] = 0; owner[i] = 0;
        end
        reset = 1'b1; frameTick = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        for (int n = 0; n < RN - 10; n++) begin
            ovrPrev = ovr;
            tick = (n < RN - 80) && ($urandom_range(0, 5) == 0);
            if (n >= freeAt) begin
                if (tick || pend) begin
                    if (tick && pend && ovr < 255) ovr++;
                    pend = 1'b0;
                    planFrame(n, freeAt, st);
                end
            end else if (tick) begin
                if (pend) begin if (ovr < 255) ovr++; end
                else pend = 1'b1;
            end
            frameTick      = tick;
            currentState   = st;
            bus.bgDone     = doneBg[n]   || (owner[n] != 1 && $urandom_range(0, 7) == 0);
            bus.noteDone   = doneNote[n] || (owner[n] != 2 && $urandom_range(0, 7) == 0);
            bus.keyDone    = doneKey[n]  || (owner[n] != 3 && $urandom_range(0, 7) == 0);
            bus.bgX = 8'($urandom);   bus.bgY = 8'($urandom);   bus.bgColour = 24'($urandom);   bus.bgPlot = 1'($urandom);
            bus.noteX = 8'($urandom); bus.noteY = 8'($urandom); bus.noteColour = 24'($urandom); bus.notePlot = 1'($urandom);
            bus.keyX = 8'($urandom);  bus.keyY = 8'($urandom);  bus.keyColour = 24'($urandom);  bus.keyPlot = 1'($urandom);
            @(negedge clk);
            ePlot = 1'b0;
            if (prevOwn != 0) begin hx = px; hy = py; hc = pc; ePlot = pp; end
            checks++; if ({bus.bgStart, bus.noteStart, bus.keyStart} !== {expBgS[n], expNoteS[n], expKeyS[n]}) begin errors++; $display("FAIL rand_starts@%0d: got %b want %b", n, {bus.bgStart, bus.noteStart, bus.keyStart}, {expBgS[n], expNoteS[n], expKeyS[n]}); end
            checks++; if (busy !== expBusy[n]) begin errors++; $display("FAIL rand_busy@%0d: got %0b want %0b", n, busy, expBusy[n]); end
            checks++; if (frameDone !== expFd[n]) begin errors++; $display("FAIL rand_frameDone@%0d: got %0b want %0b", n, frameDone, expFd[n]); end
            checks++; if (overrunCount !== 8'(ovrPrev)) begin errors++; $display("FAIL rand_overrun@%0d: got %0d want %0d", n, overrunCount, ovrPrev); end
            checks++; if (timeoutFlag !== 1'b0) begin errors++; $display("FAIL rand_timeout@%0d: got %0b want 0", n, timeoutFlag); end
            checks++; if (bus.vgaPlot !== ePlot) begin errors++; $display("FAIL rand_plot@%0d: got %0b want %0b", n, bus.vgaPlot, ePlot); end
            checks++; if ({bus.vgaX, bus.vgaY, bus.vgaColour} !== {hx, hy, hc}) begin errors++; $display("FAIL rand_pixel@%0d: got %0h want %0h", n, {bus.vgaX, bus.vgaY, bus.vgaColour}, {hx, hy, hc}); end
            prevOwn = owner[n];
            case (prevOwn)
                1: begin px = bus.bgX;   py = bus.bgY;   pc = bus.bgColour;   pp = bus.bgPlot;   end
                2: begin px = bus.noteX; py = bus.noteY; pc = bus.noteColour; pp = bus.notePlot; end
                3: begin px = bus.keyX;  py = bus.keyY;  pc = bus.keyColour;  pp = bus.keyPlot;  end
                default: pp = 1'b0;
            endcase
            @(posedge clk); #1;
        end
        frameTick = 1'b0;
        bus.bgDone = 1'b0; bus.noteDone = 1'b0; bus.keyDone = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frameTick = 1'b0; currentState = 5'd0;
        bus.bgDone = 1'b0; bus.noteDone = 1'b0; bus.keyDone = 1'b0;
        bus.bgX = 8'd0; bus.bgY = 8'd0; bus.bgColour = 24'd0; bus.bgPlot = 1'b0;
        bus.noteX = 8'd0; bus.noteY = 8'd0; bus.noteColour = 24'd0; bus.notePlot = 1'b0;
        bus.keyX = 8'd0; bus.keyY = 8'd0; bus.keyColour = 24'd0; bus.keyPlot = 1'b0;
        test_reset();
        test_normal_frame();
        test_record_skip();
        test_bus_isolation();
        test_overrun();
        test_reset_mid_pass();
`ifdef DRAW_WATCHDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
